sw_alloc: RTL and testbench
===========================

SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 5, meaning the router port count, indexed N=0, S=1, E=2, W=3, L=4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req_valid_i, input, 5 bits: input port i has a head-of-queue flit.
REQ-005 The module SHALL have port req_dest_i, input, 5x3 bits: the output port requested by input i.
REQ-006 The module SHALL have port req_tail_i, input, 5 bits: the flit at input i is a tail or single-flit packet.
REQ-007 The module SHALL have port credit_en_i, input, 5 bits: output o has downstream credit, driven from the flow-control counters.
REQ-008 The module SHALL have port gnt_o, output, 5 bits: the flit at input i advances this cycle.
REQ-009 The module SHALL have port xbar_sel_o, output, 5x3 bits: the input index driving output o.
REQ-010 The module SHALL have port xbar_valid_o, output, 5 bits: output o carries a flit this cycle.
REQ-011 The module SHALL have port credit_decr_o, output, 5 bits: consume one credit of output o; equal to xbar_valid_o.

Function
REQ-012 Each output o SHALL run an independent 2-state FSM (IDLE, LOCKED) with a 3-bit round-robin pointer ptr and a 3-bit owner register.
REQ-013 In IDLE, the candidates for output o SHALL be the inputs with req_valid_i set and req_dest_i equal to o.
REQ-014 The IDLE winner SHALL be the first candidate found scanning from ptr+1 upward, wrapping from 4 to 0.
REQ-015 An IDLE transfer SHALL occur only when credit_en_i[o] is set and at least one candidate exists.
REQ-016 On an IDLE transfer with a tail flit, the FSM SHALL stay in IDLE and set ptr to the winner.
REQ-017 On an IDLE transfer with a non-tail flit, the FSM SHALL move to LOCKED and set owner to the winner.
REQ-018 In LOCKED, only the owner SHALL be eligible; a transfer occurs when the owner is valid, its dest equals o and credit_en_i[o] is set.
REQ-019 A tail transfer in LOCKED SHALL return the FSM to IDLE with ptr set to owner.
REQ-020 In LOCKED, an absent owner flit or missing credit SHALL stall with no transfer and no state change.
REQ-021 Grant SHALL be combinational, with 0-cycle latency from request to gnt_o, xbar_valid_o and credit_decr_o; state updates on the next clk edge.
REQ-022 gnt_o[i] SHALL be set iff some output transfers from input i, so at most one output per input.
REQ-023 When xbar_valid_o[o] is 0, xbar_sel_o[o] SHALL be 0.
REQ-024 A req_dest_i value of 5..7 SHALL never be granted and SHALL not affect any FSM.
REQ-025 Credit SHALL be checked in the same cycle as the transfer, so no output issues a transfer with credit_en_i low.

Reset
REQ-026 While rst is high, all outputs SHALL be 0 regardless of inputs.
REQ-027 On rst, every FSM SHALL go to IDLE, ptr SHALL be 4 (north first priority) and owner SHALL be 0.
REQ-028 Reset during LOCKED SHALL abandon the packet lock; upstream flushing of partial packets is outside this block.

Structure
REQ-029 Package noc_pkg SHALL hold NUM_PORTS, the port_t enum (N, S, E, W, L) and the arbiter state enum (IDLE, LOCKED).
REQ-030 Sub-module out_arb SHALL implement one output's FSM, pointer and owner, and sw_alloc SHALL instantiate it NUM_PORTS times and OR the per-output grants into gnt_o.

Verification
REQ-031 After reset, with N, E and L all requesting output S as single-flit packets and credit held high, the bench SHALL see grants in the order N, E, L, N across consecutive cycles.
REQ-032 With W sending a 3-flit packet to output L while N also requests L, the bench SHALL see W granted for 3 consecutive cycles and N granted on the 4th.
REQ-033 With a locked owner holding and credit_en_i[o] dropped for 2 cycles, the bench SHALL see no transfer and no change of owner, and the transfer SHALL resume when credit returns.
REQ-034 With all five inputs targeting five distinct outputs and all credits high, the bench SHALL see gnt_o=5'b11111 in a single cycle.
REQ-035 With an input requesting dest=6, the bench SHALL see gnt_o stay 0 indefinitely and the other outputs unaffected.
REQ-036 With rst asserted mid-packet while LOCKED, the bench SHALL see all outputs 0 during rst, and the first arbitration after rst SHALL start from N.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the router switch allocator.
// Holds the router port count, the port naming enum, the per-output
// arbiter state enum and a small wrap-around index helper.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = 3;

  // Router port indices.
  typedef enum logic [PORT_W-1:0] {
    N = 3'd0,
    S = 3'd1,
    E = 3'd2,
    W = 3'd3,
    L = 3'd4
  } port_t;

  // Per-output arbiter state.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Pointer value after reset: the last port, so the first scan starts at N.
  localparam logic [PORT_W-1:0] RESET_PTR = PORT_W'(NUM_PORTS - 1);

  // (p + step) modulo np, used to walk the round-robin scan order.
  function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] p,
                                                 input int step,
                                                 input int np);
    int s;
    s = int'(p) + step;
    return PORT_W'(s % np);
  endfunction

endpackage

// File: rtl/out_arb.sv
// One output port's arbiter: round-robin selection among inputs while IDLE,
// and packet-level locking to a single owner until its tail flit passes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_valid_i     - per-input head-of-queue valid
//   req_dest_i      - per-input requested output index
//   req_tail_i      - per-input tail / single-flit marker
//   credit_en_i     - this output has downstream credit
//   gnt_o           - one-hot input granted by this output (0 if none)
//   sel_o           - input index driving this output (0 when not valid)
//   valid_o         - this output carries a flit this cycle
module out_arb
  import noc_pkg::*;
#(
  parameter int NP      = NUM_PORTS,
  parameter int OUT_IDX = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NP-1:0]             req_valid_i,
  input  logic [NP-1:0][PORT_W-1:0] req_dest_i,
  input  logic [NP-1:0]             req_tail_i,
  input  logic                      credit_en_i,
  output logic [NP-1:0]             gnt_o,
  output logic [PORT_W-1:0]         sel_o,
  output logic                      valid_o
);

  localparam logic [PORT_W-1:0] MY_ID = PORT_W'(OUT_IDX);

  arb_state_t          state_q, state_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;
  logic [PORT_W-1:0]   owner_q, owner_d;

  logic [NP-1:0]       cand_s;
  logic                found_s;
  logic [PORT_W-1:0]   win_s;
  logic                xfer_s;
  logic [PORT_W-1:0]   src_s;

  // Inputs currently asking for this output; out-of-range dests never match.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < NP; i++) begin
      cand_s[i] = req_valid_i[i] && (req_dest_i[i] == MY_ID);
    end
  end

  // Round-robin pick: first candidate after ptr, wrapping, keeping the earliest hit.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 1; k <= NP; k++) begin
      win_s   = (!found_s && cand_s[wrap_add(ptr_q, k, NP)]) ? wrap_add(ptr_q, k, NP) : win_s;
      found_s = found_s | cand_s[wrap_add(ptr_q, k, NP)];
    end
  end

  // Next-state logic: IDLE arbitrates, LOCKED serves only the owner until its tail.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    xfer_s  = 1'b0;
    src_s   = '0;
    case (state_q)
      IDLE: begin
        if (credit_en_i && found_s) begin
          xfer_s = 1'b1;
          src_s  = win_s;
          if (req_tail_i[win_s]) begin
            ptr_d = win_s;
          end else begin
            state_d = LOCKED;
            owner_d = win_s;
          end
        end else begin
          xfer_s = 1'b0;
        end
      end
      LOCKED: begin
        // A missing owner flit or missing credit simply stalls the lock.
        if (credit_en_i && req_valid_i[owner_q] && (req_dest_i[owner_q] == MY_ID)) begin
          xfer_s = 1'b1;
          src_s  = owner_q;
          if (req_tail_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = owner_q;
          end else begin
            state_d = LOCKED;
          end
        end else begin
          xfer_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    gnt_o   = '0;
    sel_o   = '0;
    valid_o = 1'b0;
    if (xfer_s && !rst) begin
      valid_o      = 1'b1;
      sel_o        = src_s;
      gnt_o[src_s] = 1'b1;
    end else begin
      valid_o = 1'b0;
    end
  end

  // State, pointer and owner registers; reset abandons any packet lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= RESET_PTR;
      owner_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Router switch allocator: one out_arb per output port, with the per-output
// grants merged into a per-input grant vector.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_valid_i     - input i has a head-of-queue flit
//   req_dest_i      - output requested by input i (5..7 never granted)
//   req_tail_i      - flit at input i is a tail or single-flit packet
//   credit_en_i     - output o has downstream credit
//   gnt_o           - flit at input i advances this cycle
//   xbar_sel_o      - input index driving output o (0 when idle)
//   xbar_valid_o    - output o carries a flit this cycle
//   credit_decr_o   - consume one credit of output o (same as xbar_valid_o)
module sw_alloc #(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               req_valid_i,
  input  logic [NUM_PORTS-1:0][2:0]          req_dest_i,
  input  logic [NUM_PORTS-1:0]               req_tail_i,
  input  logic [NUM_PORTS-1:0]               credit_en_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  output logic [NUM_PORTS-1:0][2:0]          xbar_sel_o,
  output logic [NUM_PORTS-1:0]               xbar_valid_o,
  output logic [NUM_PORTS-1:0]               credit_decr_o
);

  import noc_pkg::*;

  // arb_gnt_s[o][i]: output o grants input i.
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] arb_gnt_s;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    out_arb #(
      .NP      (NUM_PORTS),
      .OUT_IDX (o)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_dest_i  (req_dest_i),
      .req_tail_i  (req_tail_i),
      .credit_en_i (credit_en_i[o]),
      .gnt_o       (arb_gnt_s[o]),
      .sel_o       (xbar_sel_o[o]),
      .valid_o     (xbar_valid_o[o])
    );
  end

  // An input requests exactly one output, so OR-ing the per-output grants is exclusive.
  always_comb begin
    gnt_o = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_o = gnt_o | arb_gnt_s[o];
    end
  end

  assign credit_decr_o = xbar_valid_o;

endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the rules.
module tb_sw_alloc;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       req_valid_i;
  logic [4:0][2:0]  req_dest_i;
  logic [4:0]       req_tail_i;
  logic [4:0]       credit_en_i;
  logic [4:0]       gnt_o;
  logic [4:0][2:0]  xbar_sel_o;
  logic [4:0]       xbar_valid_o;
  logic [4:0]       credit_decr_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state per output: locked flag, round-robin pointer, owner.
  bit m_locked[5];
  int m_ptr[5];
  int m_owner[5];
  bit n_locked[5];
  int n_ptr[5];
  int n_owner[5];
  logic [4:0]      e_gnt;
  logic [4:0]      e_valid;
  logic [4:0][2:0] e_sel;

  always #5 clk = ~clk;

  sw_alloc #(.NUM_PORTS(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_dest_i    (req_dest_i),
    .req_tail_i    (req_tail_i),
    .credit_en_i   (credit_en_i),
    .gnt_o         (gnt_o),
    .xbar_sel_o    (xbar_sel_o),
    .xbar_valid_o  (xbar_valid_o),
    .credit_decr_o (credit_decr_o)
  );

  function automatic logic [4:0][2:0] mkd(input logic [2:0] d0, input logic [2:0] d1,
                                          input logic [2:0] d2, input logic [2:0] d3,
                                          input logic [2:0] d4);
    logic [4:0][2:0] r;
    r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3; r[4] = d4;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current inputs, derived from the arbitration rules.
  task automatic model_eval();
    e_gnt = '0; e_valid = '0; e_sel = '0;
    for (int o = 0; o < 5; o++) begin
      int win;
      n_locked[o] = m_locked[o]; n_ptr[o] = m_ptr[o]; n_owner[o] = m_owner[o];
      win = -1;
      if (!rst && credit_en_i[o]) begin
        if (!m_locked[o]) begin
          for (int k = 1; k <= 5; k++) begin
            int i;
            i = (m_ptr[o] + k) % 5;
            if (win < 0 && req_valid_i[i] && int'(req_dest_i[i]) == o) win = i;
          end
        end else if (req_valid_i[m_owner[o]] && int'(req_dest_i[m_owner[o]]) == o) begin
          win = m_owner[o];
        end
      end
      if (win >= 0) begin
        e_valid[o] = 1'b1;
        e_sel[o]   = 3'(win);
        e_gnt[win] = 1'b1;
        if (req_tail_i[win]) begin
          n_locked[o] = 1'b0; n_ptr[o] = win;
        end else begin
          n_locked[o] = 1'b1; n_owner[o] = win;
        end
      end
    end
  endtask

  // Apply inputs away from the clock edge and compare all outputs to the model.
  task automatic drive(input logic r, input logic [4:0] v, input logic [4:0][2:0] d,
                       input logic [4:0] t, input logic [4:0] c);
    @(negedge clk);
    rst = r; req_valid_i = v; req_dest_i = d; req_tail_i = t; credit_en_i = c;
    #1;
    model_eval();
    check("gnt_model",   {27'd0, gnt_o},         {27'd0, e_gnt});
    check("sel_model",   {17'd0, xbar_sel_o},    {17'd0, e_sel});
    check("valid_model", {27'd0, xbar_valid_o},  {27'd0, e_valid});
    check("decr_model",  {27'd0, credit_decr_o}, {27'd0, e_valid});
  endtask

  // Clock edge: advance the model the same way the state should advance.
  task automatic tick();
    @(posedge clk);
    for (int o = 0; o < 5; o++) begin
      if (rst) begin
        m_locked[o] = 1'b0; m_ptr[o] = 4; m_owner[o] = 0;
      end else begin
        m_locked[o] = n_locked[o]; m_ptr[o] = n_ptr[o]; m_owner[o] = n_owner[o];
      end
    end
  endtask

  initial begin
    logic [4:0][2:0] d;
    logic [4:0] exp_g[4];
    rst = 1'b1; req_valid_i = '0; req_dest_i = '0; req_tail_i = '0; credit_en_i = '0;

    // Reset with busy inputs: every output must stay 0.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 5'b11111, mkd(3'd1, 3'd2, 3'd3, 3'd4, 3'd0), 5'(n), 5'b11111);
      check("rst_gnt",   {27'd0, gnt_o}, 32'd0);
      check("rst_valid", {27'd0, xbar_valid_o}, 32'd0);
      tick();
    end

    // N, E, L all to S, single flits: order N, E, L, N.
    exp_g[0] = 5'b00001; exp_g[1] = 5'b00100; exp_g[2] = 5'b10000; exp_g[3] = 5'b00001;
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 5'b10101, mkd(3'd1, 3'd1, 3'd1, 3'd1, 3'd1), 5'b11111, 5'b11111);
      check("rr_order", {27'd0, gnt_o}, {27'd0, exp_g[n]});
      check("rr_sel", {29'd0, xbar_sel_o[1]}, n == 0 ? 32'd0 : n == 1 ? 32'd2 : n == 2 ? 32'd4 : 32'd0);
      tick();
    end
    drive(1'b0, 5'b00000, '0, 5'b00000, 5'b11111); tick();

    // Move L's pointer to N, then W 3-flit packet to L against N.
    drive(1'b0, 5'b00001, mkd(3'd4, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00001, 5'b11111);
    check("pre_lock", {27'd0, gnt_o}, 32'h01);
    tick();
    for (int n = 0; n < 4; n++) begin
      d = mkd(3'd4, 3'd0, 3'd0, 3'd4, 3'd0);
      drive(1'b0, n < 3 ? 5'b01001 : 5'b00001, d, n == 2 ? 5'b01001 : 5'b00001, 5'b11111);
      check("pkt_lock", {27'd0, gnt_o}, n < 3 ? 32'h08 : 32'h01);
      tick();
    end

    // S 3-flit packet to E with credit dropped for 2 cycles; N waits behind the lock.
    d = mkd(3'd2, 3'd2, 3'd0, 3'd0, 3'd0);
    drive(1'b0, 5'b00010, d, 5'b00000, 5'b11111);
    check("stall_head", {27'd0, gnt_o}, 32'h02); tick();
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, 5'b00011, d, 5'b00001, 5'b11011);
      check("stall_gnt", {27'd0, gnt_o}, 32'd0);
      check("stall_valid", {29'd0, xbar_valid_o[2]}, 32'd0);
      tick();
    end
    drive(1'b0, 5'b00011, d, 5'b00001, 5'b11111);
    check("resume_body", {27'd0, gnt_o}, 32'h02); tick();
    drive(1'b0, 5'b00011, d, 5'b00011, 5'b11111);
    check("resume_tail", {27'd0, gnt_o}, 32'h02); tick();
    drive(1'b0, 5'b00001, d, 5'b00001, 5'b11111);
    check("after_unlock", {27'd0, gnt_o}, 32'h01); tick();

    // All five inputs to distinct outputs in one cycle.
    drive(1'b0, 5'b11111, mkd(3'd1, 3'd2, 3'd3, 3'd4, 3'd0), 5'b11111, 5'b11111);
    check("full_xbar", {27'd0, gnt_o}, 32'h1F);
    check("full_sel", {17'd0, xbar_sel_o}, {17'd0, mkd(3'd4, 3'd0, 3'd1, 3'd2, 3'd3)});
    tick();

    // Out-of-range destination is never granted and does not disturb others.
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, n < 3 ? 5'b00100 : 5'b00101, mkd(3'd1, 3'd0, 3'd6, 3'd0, 3'd0), 5'b11111, 5'b11111);
      check("bad_dest", {27'd0, gnt_o}, n < 3 ? 32'd0 : 32'h01);
      tick();
    end

    // Lock W with an N head, reset mid-packet, then arbitrate from N again.
    drive(1'b0, 5'b00001, mkd(3'd3, 3'd0, 3'd0, 3'd0, 3'd0), 5'b00000, 5'b11111);
    check("lock_w", {27'd0, gnt_o}, 32'h01); tick();
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 5'b11111, mkd(3'd3, 3'd3, 3'd3, 3'd3, 3'd3), 5'b00000, 5'b11111);
      check("midrst_gnt", {27'd0, gnt_o}, 32'd0);
      check("midrst_sel", {17'd0, xbar_sel_o}, 32'd0);
      check("midrst_decr", {27'd0, credit_decr_o}, 32'd0);
      tick();
    end
    drive(1'b0, 5'b10010, mkd(3'd3, 3'd3, 3'd3, 3'd3, 3'd3), 5'b11111, 5'b11111);
    check("post_rst_first", {27'd0, gnt_o}, 32'h02); tick();

    // Random traffic with occasional reset, dropped credit and bad destinations.
    for (int n = 0; n < 400; n++) begin
      logic [4:0][2:0] rd;
      for (int i = 0; i < 5; i++) begin
        rd[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      end
      drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 5'($urandom), rd, 5'($urandom),
            5'($urandom) | 5'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
